// File: rtl/aes_pkg.sv
// aes_pkg: shared AES primitives for the key schedule and cipher rounds.
//   AES_NR    number of rounds for AES-128
//   sbox      forward S-box lookup (256-entry table)
//   rot_word  cyclic left byte rotation of a 32-bit word
//   rcon      round constant byte for rounds 1..10, 0 otherwise
//   rev_state_e  states of the reverse key walk controller
package aes_pkg;

  localparam int AES_NR = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } rev_state_e;

  localparam logic [7:0] SBOX_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[b];
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] rc;
    case (round)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes_inv_key_step.sv
// aes_inv_key_step: one backwards step of the AES-128 key schedule.
//   key       round key r, word order {w0,w1,w2,w3}, MSB = w0[31]
//   round     r, the index of the key being left (1..10)
//   prev_key  round key r-1, same word order
// Purely combinational; holds the single SubWord (four S-box lookups).
module aes_inv_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key,
  input  logic [3:0]   round,
  output logic [127:0] prev_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] p0, p1, p2, p3;
  logic [31:0] rot;
  logic [31:0] sub;

  assign w0 = key[127:96];
  assign w1 = key[95:64];
  assign w2 = key[63:32];
  assign w3 = key[31:0];

  // The forward schedule XOR-chains each word into the next, so undoing it
  // only needs neighbouring XORs; the recovered p3 then feeds the g() term.
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;

  assign rot = rot_word(p3);
  assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};

  assign p0 = w0 ^ sub ^ {rcon(round), 24'h0};

  assign prev_key = {p0, p1, p2, p3};

endmodule

// File: rtl/aes_key_reverse.sv
// aes_key_reverse: iterative reverse AES-128 key schedule.
// Loads round key LAST_ROUND and emits round keys LAST_ROUND..0 on a
// valid/ready stream, one inverse step per accepted key.
//   clk, rst            clock, async active-high reset
//   start, last_key     begin a walk from last_key (sampled only when idle)
//   busy                walk in progress
//   rk_valid, rk_ready  round key stream handshake
//   rk_index, round_key current round number and key
//   done                one-cycle pulse after key 0 is accepted
//   key_out             recovered cipher key, updated at done
//
// state   | meaning
// ST_IDLE | waiting for start; outputs idle, key_out holds
// ST_EMIT | presenting round_key/rk_index; steps back on each handshake
module aes_key_reverse
  import aes_pkg::*;
#(
  parameter int LAST_ROUND = AES_NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] last_key,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_index,
  output logic [127:0] round_key,
  output logic         done,
  output logic [127:0] key_out
);

  if (LAST_ROUND < 1 || LAST_ROUND > 15) begin : g_last_round_check
    $error("LAST_ROUND does not fit the 4-bit round index");
  end

  rev_state_e   state_q, state_d;
  logic [127:0] key_q;
  logic [3:0]   idx_q;
  logic [127:0] key_out_q;
  logic         done_q;
  logic [127:0] prev_key;

  logic         load;
  logic         step;
  logic         finish;

  aes_inv_key_step u_step (
    .key      (key_q),
    .round    (idx_q),
    .prev_key (prev_key)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (rk_ready) begin
          if (idx_q == 4'd0) begin
            finish  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            step = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q     <= '0;
      idx_q     <= '0;
      key_out_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= finish;
      if (load) begin
        key_q <= last_key;
        idx_q <= 4'(LAST_ROUND);
      end else if (step) begin
        key_q <= prev_key;
        idx_q <= idx_q - 4'd1;
      end
      if (finish) begin
        key_out_q <= key_q;
      end
    end
  end

  assign rk_valid  = (state_q == ST_EMIT);
  assign busy      = (state_q == ST_EMIT);
  assign rk_index  = idx_q;
  assign round_key = key_q;
  assign done      = done_q;
  assign key_out   = key_out_q;

endmodule

// File: tb/tb_aes_key_reverse.sv
module tb_aes_key_reverse;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] last_key;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [3:0]   rk_index;
  logic [127:0] round_key;
  logic         done;
  logic [127:0] key_out;

  aes_key_reverse #(.LAST_ROUND(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .last_key  (last_key),
    .busy      (busy),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_index  (rk_index),
    .round_key (round_key),
    .done      (done),
    .key_out   (key_out)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model: forward key expansion ----------------
  logic [7:0]   sb [256];
  logic [127:0] model [0:10];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] b, inv;
    for (int v = 0; v < 256; v++) begin
      b   = 8'(v);
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(b, 8'(x)) == 8'h01) inv = 8'(x);
      sb[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
              {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] ck);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = ck[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++)
      model[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- ready driver ----------------
  bit bp_mode = 1'b0;
  always @(posedge clk) begin
    #1;
    rk_ready = bp_mode ? ($urandom_range(0, 99) >= 30) : 1'b1;
  end

  // ---------------- compare process ----------------
  bit           in_walk = 1'b0;
  logic [3:0]   exp_idx = 4'd0;
  bit           pend_done = 1'b0;
  logic [127:0] pend_key = '0;
  logic [127:0] key_out_exp = '0;
  int           done_count = 0;
  int           hs_count = 0;
  bit           prev_stall = 1'b0;
  logic [127:0] prev_rk = '0;
  logic [3:0]   prev_idx = '0;

  always @(negedge clk) begin
    if (rst) begin
      in_walk     = 1'b0;
      pend_done   = 1'b0;
      prev_stall  = 1'b0;
      key_out_exp = '0;
    end else begin
      check("done", 128'(done), 128'(pend_done));
      check("busy", 128'(busy), 128'(rk_valid));
      check("key_out", key_out, pend_done ? pend_key : key_out_exp);
      if (pend_done) key_out_exp = pend_key;
      if (done) done_count++;
      pend_done = 1'b0;
      if (rk_valid) begin
        if (!in_walk) begin
          in_walk  = 1'b1;
          exp_idx  = 4'd10;
          hs_count = 0;
        end
        if (prev_stall) begin
          check("stall_hold_key", round_key, prev_rk);
          check("stall_hold_idx", 128'(rk_index), 128'(prev_idx));
        end
        check("rk_index", 128'(rk_index), 128'(exp_idx));
        check("round_key", round_key, model[exp_idx]);
        prev_stall = !rk_ready;
        prev_rk    = round_key;
        prev_idx   = rk_index;
        if (rk_ready) begin
          hs_count++;
          if (exp_idx == 4'd0) begin
            pend_done = 1'b1;
            pend_key  = model[0];
            in_walk   = 1'b0;
          end else begin
            exp_idx = exp_idx - 4'd1;
          end
        end
      end else begin
        prev_stall = 1'b0;
        check("valid_dropped_mid_walk", 128'(in_walk), 128'(0));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_walk(input logic [127:0] ck);
    expand(ck);
    last_key = model[10];
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    last_key = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  // Returns at the negedge on which done is seen (or the budget expires).
  task automatic wait_done(input bit spurious, output int cycles, output int first_v);
    cycles  = 0;
    first_v = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (rk_valid && first_v == 0) first_v = cycles;
      if (spurious && !done && (cycles % 3 == 1)) begin
        start    = 1'b1;
        last_key = {$urandom(), $urandom(), $urandom(), $urandom()};
      end else begin
        start = 1'b0;
      end
    end while (!done && cycles < 2000);
    start = 1'b0;
    check("walk_done_seen", 128'(done), 128'(1));
  endtask

  int cyc, fv, dc, guard;

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    last_key = '0;
    rk_ready = 1'b1;
    build_sbox();

    // reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_valid", 128'(rk_valid), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_index", 128'(rk_index), 128'(0));
    check("rst_round_key", round_key, 128'(0));
    check("rst_key_out", key_out, 128'(0));
    #1 rst = 1'b0;

    // pin the model to published values
    expand(FIPS_KEY);
    check("model_fips_rk10", model[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("model_fips_rk9", model[9], 128'hac7766f319fadc2128d12941575c006e);
    check("model_fips_rk1", model[1], 128'ha0fafe1788542cb123a339392a6c7605);
    expand(128'h0);
    check("model_zero_rk10", model[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    check("model_zero_rk1", model[1], 128'h62636363626363636263636362636363);

    // FIPS vector, ready held high
    @(posedge clk); #1;
    start_walk(FIPS_KEY);
    wait_done(1'b0, cyc, fv);
    check("fips_first_valid_cycle", 128'(fv), 128'(1));
    check("fips_done_cycle", 128'(cyc), 128'(12));
    check("fips_key_out", key_out, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    check("fips_handshakes", 128'(hs_count), 128'(11));

    // zero cipher key
    @(posedge clk); #1;
    start_walk(128'h0);
    wait_done(1'b0, cyc, fv);
    check("zero_key_out", key_out, 128'h0);
    check("zero_done_cycle", 128'(cyc), 128'(12));

    // backpressure plus spurious starts during EMIT
    bp_mode = 1'b1;
    @(posedge clk); #1;
    dc = done_count;
    start_walk(FIPS_KEY);
    wait_done(1'b1, cyc, fv);
    check("bp_handshakes", 128'(hs_count), 128'(11));
    @(negedge clk);
    check("bp_one_done", 128'(done_count), 128'(dc + 1));
    check("bp_key_out", key_out, FIPS_KEY);

    // random keys under backpressure
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      start_walk({$urandom(), $urandom(), $urandom(), $urandom()});
      wait_done(1'b0, cyc, fv);
      check("rand_handshakes", 128'(hs_count), 128'(11));
    end

    // start in the done cycle begins the next walk right away
    bp_mode = 1'b0;
    @(posedge clk); #1;
    start_walk({$urandom(), $urandom(), $urandom(), $urandom()});
    wait_done(1'b0, cyc, fv);
    start_walk(FIPS_KEY);
    wait_done(1'b0, cyc, fv);
    check("b2b_first_valid_cycle", 128'(fv), 128'(1));
    check("b2b_done_cycle", 128'(cyc), 128'(12));
    check("b2b_key_out", key_out, FIPS_KEY);

    // reset mid-walk at index 6
    @(posedge clk); #1;
    start_walk(128'h0);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(rk_valid && rk_index == 4'd6) && guard < 50);
    check("reach_index6", 128'(rk_index), 128'(6));
    dc = done_count;
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", 128'(busy), 128'(0));
    check("async_rst_valid", 128'(rk_valid), 128'(0));
    check("async_rst_done", 128'(done), 128'(0));
    check("async_rst_index", 128'(rk_index), 128'(0));
    check("async_rst_round_key", round_key, 128'(0));
    check("async_rst_key_out", key_out, 128'(0));
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_no_done", 128'(done_count), 128'(dc));
    check("rst_idle", 128'(rk_valid), 128'(0));

    // fresh walk after reset
    @(posedge clk); #1;
    start_walk(FIPS_KEY);
    wait_done(1'b0, cyc, fv);
    check("post_rst_done_cycle", 128'(cyc), 128'(12));
    check("post_rst_handshakes", 128'(hs_count), 128'(11));
    check("post_rst_key_out", key_out, FIPS_KEY);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
